reorder_buffer: RTL and testbench

Parametrised reorder buffer for the out-of-order core: circular, tag-addressed, in-order allocate and retire, with `NUM_CDB` writeback (CDB) ports, `NUM_LOOKUP` operand-lookup ports with same-cycle CDB forwarding, and tail rollback on branch mispredict. It sits between dispatch (allocate and lookup), the commit/CDB stage (writeback), branch resolution (flush) and the register-file write port (retire). Tags run 1..DEPTH; tag 0 means "no tag".

---
 rtl/reorder_buffer_pkg.sv | 24 ++
 rtl/reorder_buffer_cdb_match.sv | 33 +++
 rtl/reorder_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: entry layout, default sizing and the tag-width helper.
// Imported by the reorder buffer top and its CDB match sub-module.
package reorder_buffer_pkg;

    localparam int ROB_SIZE   = 8;
    localparam int ROB_DATA_W = 64;
    localparam int REG_ADDR_W = 5;
    localparam int PC_W       = 64;

    // Tags run 1..depth with 0 reserved for "no tag", so depth+1 codes are needed.
    function automatic int rob_tag_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // The result value is held in a separate array because its width is a per-instance parameter.
    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwr;
        logic [PC_W-1:0]       pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_cdb_match.sv
// Compares one tag against every CDB writeback port.
// On a hit it returns the value, and the highest-numbered matching port wins.
module rob_cdb_match
    import reorder_buffer_pkg::*;
#(
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 64
) (
    input  logic [TAG_W-1:0]          tag,
    input  logic [NUM_CDB-1:0]        wb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] wb_value,
    output logic                      hit,
    output logic [DATA_W-1:0]         value
);

    // Scan ports in ascending order so a later match overrides an earlier one.
    always_comb begin
        hit   = 1'b0;
        value = '0;
        for (int p = 0; p < NUM_CDB; p++) begin
            if (wb_valid[p] && (tag != '0) && (wb_tag[p*TAG_W +: TAG_W] == tag)) begin
                hit   = 1'b1;
                value = wb_value[p*DATA_W +: DATA_W];
            end else begin
                hit   = hit;
                value = value;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular, tag-addressed reorder buffer. Entries are allocated and retired in order,
// written back from several CDB ports, looked up with CDB forwarding, and rolled back on a mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH      = ROB_SIZE,
    parameter int DATA_W     = ROB_DATA_W,
    parameter int NUM_CDB    = 2,
    parameter int NUM_LOOKUP = 2,
    parameter int TAG_W      = rob_tag_w(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    output logic [TAG_W-1:0]             alloc_tag,
    input  logic [REG_ADDR_W-1:0]        alloc_rd,
    input  logic                         alloc_regwr,
    input  logic [PC_W-1:0]              alloc_pc,
    input  logic [NUM_CDB-1:0]           wb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]     wb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]    wb_value,
    input  logic [NUM_LOOKUP*TAG_W-1:0]  lookup_tag,
    output logic [NUM_LOOKUP-1:0]        lookup_ready,
    output logic [NUM_LOOKUP*DATA_W-1:0] lookup_value,
    input  logic                         flush_valid,
    input  logic [TAG_W-1:0]             flush_tag,
    output logic                         retire_valid,
    input  logic                         retire_ready,
    output logic [TAG_W-1:0]             retire_tag,
    output logic [REG_ADDR_W-1:0]        retire_rd,
    output logic                         retire_regwr,
    output logic [DATA_W-1:0]            retire_value,
    output logic [PC_W-1:0]              retire_pc,
    output logic [TAG_W-1:0]             count,
    output logic                         full,
    output logic                         empty
);

    localparam int IDX_W = $clog2(DEPTH);

    rob_entry_t          entry_r [DEPTH];
    logic [DATA_W-1:0]   value_r [DEPTH];
    logic [IDX_W-1:0]    head_r;
    logic [IDX_W-1:0]    tail_r;
    logic [TAG_W-1:0]    count_r;
    logic                full_r;
    logic                empty_r;

    logic [DEPTH-1:0]      ent_hit_s;
    logic [DATA_W-1:0]     ent_val_s [DEPTH];
    logic [NUM_LOOKUP-1:0] lk_hit_s;
    logic [DATA_W-1:0]     lk_val_s [NUM_LOOKUP];

    logic                alloc_fire_s;
    logic                retire_fire_s;
    logic                flush_ok_s;
    logic [IDX_W-1:0]    flush_idx_s;
    logic [IDX_W-1:0]    flush_age_s;
    logic [TAG_W-1:0]    count_next_s;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] ptr);
        if (ptr == IDX_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + IDX_W'(1);
        end
    endfunction

    // Distance from the head in program order. The arithmetic is modular, so DEPTH need not be a power of two.
    function automatic logic [IDX_W-1:0] age_of(input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] head);
        if (idx >= head) begin
            return idx - head;
        end else begin
            return idx + IDX_W'(DEPTH) - head;
        end
    endfunction

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry_match
        rob_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_match (
            .tag      (TAG_W'(e + 1)),
            .wb_valid (wb_valid),
            .wb_tag   (wb_tag),
            .wb_value (wb_value),
            .hit      (ent_hit_s[e]),
            .value    (ent_val_s[e])
        );
    end

    for (genvar p = 0; p < NUM_LOOKUP; p++) begin : g_lookup_match
        rob_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_match (
            .tag      (lookup_tag[p*TAG_W +: TAG_W]),
            .wb_valid (wb_valid),
            .wb_tag   (wb_tag),
            .wb_value (wb_value),
            .hit      (lk_hit_s[p]),
            .value    (lk_val_s[p])
        );
    end

    assign alloc_ready = !full_r && !flush_valid;
    assign alloc_tag   = TAG_W'(tail_r) + TAG_W'(1);
    assign count       = count_r;
    assign full        = full_r;
    assign empty       = empty_r;

    // Head entry presented to the register-file write port, with no writeback bypass.
    always_comb begin
        retire_valid = entry_r[head_r].valid && entry_r[head_r].ready;
        if (entry_r[head_r].valid) begin
            retire_tag = TAG_W'(head_r) + TAG_W'(1);
        end else begin
            retire_tag = '0;
        end
        retire_rd    = entry_r[head_r].rd;
        retire_regwr = entry_r[head_r].regwr;
        retire_pc    = entry_r[head_r].pc;
        retire_value = value_r[head_r];
    end

    // Decode this cycle's allocate, retire and flush events, and compute the next occupancy.
    always_comb begin
        alloc_fire_s  = alloc_valid && alloc_ready;
        retire_fire_s = retire_valid && retire_ready;
        flush_idx_s   = IDX_W'(flush_tag - TAG_W'(1));
        if (flush_valid && (flush_tag != '0) && (flush_tag <= TAG_W'(DEPTH))) begin
            flush_ok_s = entry_r[flush_idx_s].valid;
        end else begin
            flush_ok_s = 1'b0;
        end
        flush_age_s = age_of(flush_idx_s, head_r);
        if (flush_ok_s) begin
            count_next_s = TAG_W'(flush_age_s) + TAG_W'(1) - TAG_W'(retire_fire_s);
        end else begin
            count_next_s = count_r + TAG_W'(alloc_fire_s) - TAG_W'(retire_fire_s);
        end
    end

    // Operand lookup: a same-cycle CDB hit is used first, then the stored ready value.
    always_comb begin
        logic [TAG_W-1:0] lk_tag;
        logic [IDX_W-1:0] lk_idx;
        lookup_ready = '0;
        lookup_value = '0;
        for (int p = 0; p < NUM_LOOKUP; p++) begin
            lk_tag = lookup_tag[p*TAG_W +: TAG_W];
            lk_idx = IDX_W'(lk_tag - TAG_W'(1));
            if ((lk_tag == '0) || (lk_tag > TAG_W'(DEPTH))) begin
                lookup_ready[p] = 1'b0;
            end else if (lk_hit_s[p]) begin
                lookup_ready[p]                  = 1'b1;
                lookup_value[p*DATA_W +: DATA_W] = lk_val_s[p];
            end else if (entry_r[lk_idx].valid && entry_r[lk_idx].ready) begin
                lookup_ready[p]                  = 1'b1;
                lookup_value[p*DATA_W +: DATA_W] = value_r[lk_idx];
            end else begin
                lookup_ready[p] = 1'b0;
            end
        end
    end

    // Head, tail and occupancy. The flush rollback takes priority over allocate on the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (flush_ok_s) begin
                tail_r <= ptr_inc(flush_idx_s);
            end else if (alloc_fire_s) begin
                tail_r <= ptr_inc(tail_r);
            end else begin
                tail_r <= tail_r;
            end
            if (retire_fire_s) begin
                head_r <= ptr_inc(head_r);
            end else begin
                head_r <= head_r;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == TAG_W'(DEPTH));
            empty_r <= (count_next_s == '0);
        end
    end

    // Per-entry update. Squash and retire clear the slot and override any writeback in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                entry_r[e] <= '0;
                value_r[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (flush_ok_s && entry_r[e].valid && (age_of(IDX_W'(e), head_r) > flush_age_s)) begin
                    entry_r[e] <= '0;
                    value_r[e] <= '0;
                end else if (retire_fire_s && (IDX_W'(e) == head_r)) begin
                    entry_r[e] <= '0;
                    value_r[e] <= '0;
                end else if (alloc_fire_s && (IDX_W'(e) == tail_r)) begin
                    entry_r[e] <= '{valid: 1'b1, ready: 1'b0, rd: alloc_rd, regwr: alloc_regwr, pc: alloc_pc};
                    value_r[e] <= '0;
                end else if (ent_hit_s[e] && entry_r[e].valid) begin
                    entry_r[e].ready <= 1'b1;
                    value_r[e]       <= ent_val_s[e];
                end else begin
                    entry_r[e] <= entry_r[e];
                    value_r[e] <= value_r[e];
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer (DEPTH=4): directed scenarios, then a randomized run
// compared against a queue-based model of program order.
module tb_reorder_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 64;
    localparam int TW    = 3;

    logic           clk, reset;
    logic           alloc_valid, alloc_ready, alloc_regwr;
    logic [TW-1:0]  alloc_tag;
    logic [4:0]     alloc_rd;
    logic [63:0]    alloc_pc;
    logic [1:0]     wb_valid;
    logic [2*TW-1:0] wb_tag;
    logic [2*DW-1:0] wb_value;
    logic [2*TW-1:0] lookup_tag;
    logic [1:0]     lookup_ready;
    logic [2*DW-1:0] lookup_value;
    logic           flush_valid;
    logic [TW-1:0]  flush_tag;
    logic           retire_valid, retire_ready, retire_regwr;
    logic [TW-1:0]  retire_tag;
    logic [4:0]     retire_rd;
    logic [DW-1:0]  retire_value;
    logic [63:0]    retire_pc;
    logic [TW-1:0]  count;
    logic           full, empty;

    int errors = 0;
    int checks = 0;

    // Reference model: per-tag state plus the tags in program order, oldest first.
    logic        mv   [1:DEPTH];
    logic        mr   [1:DEPTH];
    logic [63:0] mval [1:DEPTH];
    logic [63:0] mpc  [1:DEPTH];
    logic [4:0]  mrd  [1:DEPTH];
    logic        mrw  [1:DEPTH];
    int          order[$];
    int          next_tag;

    reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DW), .NUM_CDB(2), .NUM_LOOKUP(2), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_rd(alloc_rd), .alloc_regwr(alloc_regwr), .alloc_pc(alloc_pc),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .lookup_tag(lookup_tag), .lookup_ready(lookup_ready), .lookup_value(lookup_value),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .retire_valid(retire_valid), .retire_ready(retire_ready), .retire_tag(retire_tag),
        .retire_rd(retire_rd), .retire_regwr(retire_regwr), .retire_value(retire_value),
        .retire_pc(retire_pc), .count(count), .full(full), .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        alloc_valid = 1'b0; alloc_rd = 5'd0; alloc_regwr = 1'b0; alloc_pc = 64'd0;
        wb_valid = 2'b00; wb_tag = '0; wb_value = '0; lookup_tag = '0;
        flush_valid = 1'b0; flush_tag = '0; retire_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        drive_idle();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 1); alloc_regwr = 1'b1; alloc_pc = 64'h1000 + 64'(4 * i);
            step();
        end
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        #1;
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %0b expected 1", alloc_ready); end
        checks++; if (alloc_tag !== 3'd1) begin errors++; $display("FAIL reset_alloc_tag: got %0d expected 1", alloc_tag); end
        checks++; if ({full, empty} !== 2'b01) begin errors++; $display("FAIL reset_full_empty: got %b expected 01", {full, empty}); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if ({retire_valid, retire_tag, retire_value} !== '0) begin errors++; $display("FAIL reset_retire: got v=%0b t=%0d val=%0h expected all 0", retire_valid, retire_tag, retire_value); end
        lookup_tag = {3'd2, 3'd1};
        #1;
        checks++; if (lookup_ready !== 2'b00) begin errors++; $display("FAIL reset_lookup: got %b expected 00", lookup_ready); end
        lookup_tag = '0;
    endtask

    task automatic test_alloc_full();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 1); alloc_regwr = 1'b1; alloc_pc = 64'h1000 + 64'(4 * i);
            #1;
            checks++; if ({alloc_ready, alloc_tag} !== {1'b1, 3'(i + 1)}) begin errors++; $display("FAIL alloc_tag_seq: got rdy=%0b tag=%0d expected rdy=1 tag=%0d", alloc_ready, alloc_tag, i + 1); end
            step();
        end
        #1;
        checks++; if ({full, alloc_ready, count} !== {1'b1, 1'b0, 3'd4}) begin errors++; $display("FAIL full_state: got full=%0b rdy=%0b cnt=%0d expected 1 0 4", full, alloc_ready, count); end
        checks++; if (alloc_tag !== 3'd1) begin errors++; $display("FAIL tail_wrap: got %0d expected 1", alloc_tag); end
        step();
        alloc_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL alloc_when_full: got cnt=%0d expected 4", count); end
    endtask

    task automatic test_wb_order();
        wb_valid = 2'b01; wb_tag = {3'd0, 3'd2}; wb_value = {64'd0, 64'hAA};
        step();
        wb_valid = 2'b00;
        #1;
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL wb_out_of_order: got retire_valid=%0b expected 0", retire_valid); end
        wb_valid = 2'b01; wb_tag = {3'd0, 3'd1}; wb_value = {64'd0, 64'hBB}; retire_ready = 1'b1;
        #1;
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL retire_no_bypass: got %0b expected 0", retire_valid); end
        step();
        wb_valid = 2'b00;
        #1;
        checks++; if ({retire_valid, retire_tag, retire_value, retire_rd, retire_pc} !== {1'b1, 3'd1, 64'hBB, 5'd1, 64'h1000}) begin
            errors++; $display("FAIL retire_first: got v=%0b t=%0d val=%0h rd=%0d pc=%0h expected 1 1 bb 1 1000", retire_valid, retire_tag, retire_value, retire_rd, retire_pc); end
        step();
        #1;
        checks++; if ({retire_valid, retire_tag, retire_value} !== {1'b1, 3'd2, 64'hAA}) begin errors++; $display("FAIL retire_second: got v=%0b t=%0d val=%0h expected 1 2 aa", retire_valid, retire_tag, retire_value); end
        step();
        retire_ready = 1'b0;
        #1;
        checks++; if ({retire_valid, count} !== {1'b0, 3'd2}) begin errors++; $display("FAIL after_retire: got v=%0b cnt=%0d expected 0 2", retire_valid, count); end
    endtask

    task automatic test_forward();
        lookup_tag = {3'd0, 3'd3}; wb_valid = 2'b10; wb_tag = {3'd3, 3'd0}; wb_value = {64'h55, 64'd0};
        #1;
        checks++; if ({lookup_ready, lookup_value[63:0]} !== {2'b01, 64'h55}) begin errors++; $display("FAIL forward_same_cycle: got rdy=%b val=%0h expected 01 55", lookup_ready, lookup_value[63:0]); end
        step();
        wb_valid = 2'b00;
        #1;
        checks++; if ({lookup_ready[0], lookup_value[63:0]} !== {1'b1, 64'h55}) begin errors++; $display("FAIL lookup_stored: got rdy=%b val=%0h expected 1 55", lookup_ready[0], lookup_value[63:0]); end
        lookup_tag = {3'd4, 3'd1}; wb_valid = 2'b11; wb_tag = {3'd4, 3'd4}; wb_value = {64'h22, 64'h11};
        #1;
        checks++; if ({lookup_ready, lookup_value[127:64]} !== {2'b10, 64'h22}) begin errors++; $display("FAIL forward_priority: got rdy=%b val=%0h expected 10 22", lookup_ready, lookup_value[127:64]); end
        step();
        wb_valid = 2'b00;
        #1;
        checks++; if ({lookup_ready[1], lookup_value[127:64]} !== {1'b1, 64'h22}) begin errors++; $display("FAIL priority_stored: got rdy=%b val=%0h expected 1 22", lookup_ready[1], lookup_value[127:64]); end
        lookup_tag = '0;
    endtask

    task automatic test_flush();
        pulse_reset();
        alloc_n(DEPTH);
        flush_valid = 1'b1; flush_tag = 3'd2; alloc_valid = 1'b1;
        #1;
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_alloc: got %0b expected 0", alloc_ready); end
        step();
        flush_valid = 1'b0; alloc_valid = 1'b0;
        #1;
        checks++; if ({count, alloc_tag, full} !== {3'd2, 3'd3, 1'b0}) begin errors++; $display("FAIL flush_rollback: got cnt=%0d tag=%0d full=%0b expected 2 3 0", count, alloc_tag, full); end
        wb_valid = 2'b11; wb_tag = {3'd2, 3'd4}; wb_value = {64'h77, 64'h99};
        step();
        wb_valid = 2'b00; lookup_tag = {3'd2, 3'd4};
        #1;
        checks++; if ({lookup_ready, lookup_value[127:64]} !== {2'b10, 64'h77}) begin errors++; $display("FAIL squashed_wb_ignored: got rdy=%b val=%0h expected 10 77", lookup_ready, lookup_value[127:64]); end
        lookup_tag = '0; flush_valid = 1'b1; flush_tag = 3'd4;
        step();
        flush_valid = 1'b0;
        #1;
        checks++; if ({count, alloc_tag} !== {3'd2, 3'd3}) begin errors++; $display("FAIL invalid_flush_ignored: got cnt=%0d tag=%0d expected 2 3", count, alloc_tag); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_val [1:DEPTH];
        int r_tag, a_tag;
        pulse_reset();
        alloc_n(DEPTH);
        wb_valid = 2'b11; wb_tag = {3'd2, 3'd1}; wb_value = {64'd102, 64'd101};
        step();
        wb_tag = {3'd4, 3'd3}; wb_value = {64'd104, 64'd103};
        step();
        wb_valid = 2'b00;
        for (int t = 1; t <= DEPTH; t++) exp_val[t] = 64'(100 + t);
        alloc_valid = 1'b1; retire_ready = 1'b1;
        #1;
        checks++; if ({alloc_ready, retire_valid, retire_tag} !== {1'b0, 1'b1, 3'd1}) begin errors++; $display("FAIL full_retire_alloc: got rdy=%0b rv=%0b rt=%0d expected 0 1 1", alloc_ready, retire_valid, retire_tag); end
        step();
        for (int i = 1; i <= 3 * DEPTH; i++) begin
            r_tag = (i % DEPTH) + 1;
            a_tag = ((i - 1) % DEPTH) + 1;
            if (i >= 2) begin
                wb_valid = 2'b01; wb_tag = {3'd0, 3'(((i - 2) % DEPTH) + 1)}; wb_value = {64'd0, 64'(200 + i)};
            end else begin
                wb_valid = 2'b00;
            end
            #1;
            checks++; if ({retire_valid, retire_tag, retire_value, alloc_ready, alloc_tag} !== {1'b1, 3'(r_tag), exp_val[r_tag], 1'b1, 3'(a_tag)}) begin
                errors++; $display("FAIL steady_%0d: got rv=%0b rt=%0d val=%0d ar=%0b at=%0d expected 1 %0d %0d 1 %0d", i, retire_valid, retire_tag, retire_value, alloc_ready, alloc_tag, r_tag, exp_val[r_tag], a_tag); end
            if (i >= 2) exp_val[((i - 2) % DEPTH) + 1] = 64'(200 + i);
            step();
            checks++; if (count !== 3'd3) begin errors++; $display("FAIL steady_count_%0d: got %0d expected 3", i, count); end
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        pulse_reset();
        alloc_n(3);
        wb_valid = 2'b11; wb_tag = {3'd2, 3'd1}; wb_value = {64'h5, 64'h6};
        #1;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_reset_count: got %0d expected 3", count); end
        #1 reset = 1'b0;
        #1;
        checks++; if ({count, empty, full, alloc_ready, alloc_tag, retire_valid, retire_tag, lookup_ready} !== {3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 2'b00}) begin
            errors++; $display("FAIL async_reset: got cnt=%0d e=%0b f=%0b ar=%0b at=%0d rv=%0b rt=%0d lr=%b expected 0 1 0 1 1 0 0 00",
                               count, empty, full, alloc_ready, alloc_tag, retire_valid, retire_tag, lookup_ready); end
        step();
        drive_idle();
        reset = 1'b1;
        step();
        checks++; if ({count, empty} !== {3'd0, 1'b1}) begin errors++; $display("FAIL post_reset_idle: got cnt=%0d e=%0b expected 0 1", count, empty); end
    endtask

    task automatic model_clear_entry(input int t);
        mv[t] = 1'b0; mr[t] = 1'b0; mval[t] = 64'd0; mpc[t] = 64'd0; mrd[t] = 5'd0; mrw[t] = 1'b0;
    endtask

    task automatic model_update(input bit ar, input bit rv);
        int t, k;
        bit fok;
        for (int p = 0; p < 2; p++) begin
            t = int'(wb_tag[p*TW +: TW]);
            if (wb_valid[p] && t >= 1 && t <= DEPTH && mv[t]) begin
                mr[t] = 1'b1; mval[t] = wb_value[p*DW +: DW];
            end
        end
        t = int'(flush_tag);
        fok = flush_valid && t >= 1 && t <= DEPTH && mv[t];
        if (fok) begin
            while (order[$] != t) begin
                k = order.pop_back();
                model_clear_entry(k);
            end
            next_tag = (t % DEPTH) + 1;
        end
        if (rv && retire_ready) begin
            k = order.pop_front();
            model_clear_entry(k);
        end
        if (ar && alloc_valid) begin
            order.push_back(next_tag);
            mv[next_tag] = 1'b1; mr[next_tag] = 1'b0; mval[next_tag] = 64'd0;
            mrd[next_tag] = alloc_rd; mrw[next_tag] = alloc_regwr; mpc[next_tag] = alloc_pc;
            next_tag = (next_tag % DEPTH) + 1;
        end
    endtask

    task automatic test_random();
        bit          e_ar, e_rv, e_lr;
        logic [63:0] e_lv;
        int          t, h;
        pulse_reset();
        for (int i = 1; i <= DEPTH; i++) model_clear_entry(i);
        order.delete();
        next_tag = 1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            alloc_valid  = ($urandom_range(0, 3) != 0);
            alloc_rd     = 5'($urandom());
            alloc_regwr  = 1'($urandom());
            alloc_pc     = {$urandom(), $urandom()};
            wb_valid     = 2'($urandom());
            wb_tag       = {3'($urandom_range(0, DEPTH)), 3'($urandom_range(0, DEPTH))};
            wb_value     = {$urandom(), $urandom(), $urandom(), $urandom()};
            lookup_tag   = {3'($urandom_range(0, DEPTH)), 3'($urandom_range(0, DEPTH))};
            flush_valid  = ($urandom_range(0, 9) == 0);
            flush_tag    = 3'($urandom_range(0, DEPTH));
            retire_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_ar = (order.size() < DEPTH) && !flush_valid;
            e_rv = (order.size() > 0) && mr[order[0]];
            checks++; if ({alloc_ready, alloc_tag, count, full, empty} !== {e_ar, 3'(next_tag), 3'(order.size()), order.size() == DEPTH, order.size() == 0}) begin
                errors++; $display("FAIL rand_ctrl cyc %0d: got ar=%0b at=%0d cnt=%0d f=%0b e=%0b expected %0b %0d %0d", cyc, alloc_ready, alloc_tag, count, full, empty, e_ar, next_tag, order.size()); end
            checks++; if (retire_valid !== e_rv) begin errors++; $display("FAIL rand_retire_valid cyc %0d: got %0b expected %0b", cyc, retire_valid, e_rv); end
            if (e_rv) begin
                h = order[0];
                checks++; if ({retire_tag, retire_value, retire_rd, retire_regwr, retire_pc} !== {3'(h), mval[h], mrd[h], mrw[h], mpc[h]}) begin
                    errors++; $display("FAIL rand_retire_fields cyc %0d: got t=%0d v=%0h rd=%0d rw=%0b pc=%0h expected %0d %0h %0d %0b %0h", cyc, retire_tag, retire_value, retire_rd, retire_regwr, retire_pc, h, mval[h], mrd[h], mrw[h], mpc[h]); end
            end
            for (int p = 0; p < 2; p++) begin
                t = int'(lookup_tag[p*TW +: TW]);
                e_lr = 1'b0; e_lv = 64'd0;
                if (t != 0) begin
                    for (int q = 0; q < 2; q++) begin
                        if (wb_valid[q] && int'(wb_tag[q*TW +: TW]) == t) begin e_lr = 1'b1; e_lv = wb_value[q*DW +: DW]; end
                    end
                    if (!e_lr && mv[t] && mr[t]) begin e_lr = 1'b1; e_lv = mval[t]; end
                end
                checks++; if ({lookup_ready[p], lookup_value[p*DW +: DW]} !== {e_lr, e_lv}) begin
                    errors++; $display("FAIL rand_lookup%0d cyc %0d: got r=%0b v=%0h expected %0b %0h", p, cyc, lookup_ready[p], lookup_value[p*DW +: DW], e_lr, e_lv); end
            end
            model_update(e_ar, e_rv);
            step();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset = 1'b0;
        test_reset();
        test_alloc_full();
        test_wb_order();
        test_forward();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
